// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MC_JAL_EN adds the JALEX state used by jal.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BREX,
        S_IMMEX,
        S_IMMWB,
        S_JEX,
`ifdef MC_JAL_EN
        S_JALEX,
`endif
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SUB,
        CLS_RTYPE,
        CLS_IMM
    } alu_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_if.sv
// Control-unit bundle: instruction fields and flags in, datapath/memory controls out.
interface mc_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             pcen;
    logic             memwrite;
    logic             irwrite;
    logic             regwrite;
    logic             alusrca;
    logic             iord;
    logic             extop;
    logic [1:0]       regdst;
    logic [1:0]       memtoreg;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic             fault;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord, extop,
               regdst, memtoreg, alusrcb, pcsrc, alucontrol, fault, instret
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord, extop,
               regdst, memtoreg, alusrcb, pcsrc, alucontrol, fault, instret
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the state's ALU class plus op/funct to alucontrol and extop.
// o_legal drops for an unknown funct (R-type) or opcode (immediate class).
module mc_aludec
    import mc_pkg::*;
(
    input  alu_cls_t   i_cls,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol,
    output logic       o_extop,
    output logic       o_legal
);

    always_comb begin
        o_alucontrol = ALU_AND;
        o_extop      = 1'b0;
        o_legal      = 1'b1;
        case (i_cls)
            CLS_ADD: o_alucontrol = ALU_ADD;
            CLS_SUB: o_alucontrol = ALU_SUB;
            CLS_RTYPE: begin
                case (i_funct)
                    F_ADD:   o_alucontrol = ALU_ADD;
                    F_SUB:   o_alucontrol = ALU_SUB;
                    F_AND:   o_alucontrol = ALU_AND;
                    F_OR:    o_alucontrol = ALU_OR;
                    F_XOR:   o_alucontrol = ALU_XOR;
                    F_SLT:   o_alucontrol = ALU_SLT;
                    default: o_legal      = 1'b0;
                endcase
            end
            CLS_IMM: begin
                case (i_op)
                    OP_ADDI: o_alucontrol = ALU_ADD;
                    OP_ANDI: begin
                        o_alucontrol = ALU_AND;
                        o_extop      = 1'b1;
                    end
                    OP_ORI: begin
                        o_alucontrol = ALU_OR;
                        o_extop      = 1'b1;
                    end
                    OP_SLTI: o_alucontrol = ALU_SLT;
                    default: o_legal      = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit with memory handshake, wait-state watchdog and
// retired-instruction counter. Define MC_JAL_EN to build the jal (JALEX) path.
//
// state    | meaning
// FETCH    | read instruction, PC+4; waits on mem_ready
// DECODE   | branch target precompute, dispatch on op
// MEMADR   | effective address for lw/sw
// MEMRD    | data read; waits on mem_ready
// MEMWB    | load writeback
// MEMWR    | data write; waits on mem_ready
// RTYPEEX  | R-type ALU op
// RTYPEWB  | R-type writeback to rd
// BREX     | beq/bne compare and conditional PC load
// IMMEX    | immediate ALU op
// IMMWB    | immediate writeback to rt
// JEX      | jump
// JALEX    | jump and link to r31
// FAULT    | sticky error, held until reset
module mc_controller
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic  i_clk,
    input  logic  i_reset,
    mc_if.master  io_bus
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;
    alu_cls_t          w_cls;
    logic [2:0]        w_alucontrol;
    logic              w_extop;
    logic              w_legal;
    logic              w_mem_wait;
    logic              w_wait_hit;

    // Completion in the cycle the count would reach MAX_WAIT wins over the fault.
    assign w_wait_hit = (r_wait == WAIT_LAST);

    mc_aludec u_aludec (
        .i_cls        (w_cls),
        .i_op         (io_bus.op),
        .i_funct      (io_bus.funct),
        .o_alucontrol (w_alucontrol),
        .o_extop      (w_extop),
        .o_legal      (w_legal)
    );

    assign io_bus.alucontrol = w_alucontrol;
    assign io_bus.extop      = w_extop;
    assign io_bus.instret    = r_instret;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_mem_wait) begin
                r_wait <= r_wait + 1'b1;
            end
            if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        w_mem_wait        = 1'b0;
        w_cls             = CLS_NONE;
        io_bus.mem_req    = 1'b0;
        io_bus.pcen       = 1'b0;
        io_bus.memwrite   = 1'b0;
        io_bus.irwrite    = 1'b0;
        io_bus.regwrite   = 1'b0;
        io_bus.alusrca    = 1'b0;
        io_bus.iord       = 1'b0;
        io_bus.regdst     = REGDST_RT;
        io_bus.memtoreg   = M2R_ALU;
        io_bus.alusrcb    = SRCB_B;
        io_bus.pcsrc      = PCSRC_ALU;
        io_bus.fault      = 1'b0;
        case (r_state)
            S_FETCH: begin
                io_bus.mem_req = 1'b1;
                io_bus.alusrcb = SRCB_FOUR;
                w_cls          = CLS_ADD;
                if (io_bus.mem_ready) begin
                    io_bus.irwrite = 1'b1;
                    io_bus.pcen    = 1'b1;
                    w_next         = S_DECODE;
                end else begin
                    w_mem_wait = 1'b1;
                    if (w_wait_hit) w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                io_bus.alusrcb = SRCB_IMMSH;
                w_cls          = CLS_ADD;
                case (io_bus.op)
                    OP_LW, OP_SW:                      w_next = S_MEMADR;
                    OP_RTYPE:                          w_next = S_RTYPEEX;
                    OP_BEQ, OP_BNE:                    w_next = S_BREX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IMMEX;
                    OP_J:                              w_next = S_JEX;
`ifdef MC_JAL_EN
                    OP_JAL:                            w_next = S_JALEX;
`endif
                    default:                           w_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                io_bus.alusrca = 1'b1;
                io_bus.alusrcb = SRCB_IMM;
                w_cls          = CLS_ADD;
                w_next         = (io_bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                io_bus.mem_req = 1'b1;
                io_bus.iord    = 1'b1;
                if (io_bus.mem_ready) begin
                    w_next = S_MEMWB;
                end else begin
                    w_mem_wait = 1'b1;
                    if (w_wait_hit) w_next = S_FAULT;
                end
            end
            S_MEMWB: begin
                io_bus.regwrite = 1'b1;
                io_bus.memtoreg = M2R_MEM;
                io_bus.regdst   = REGDST_RT;
                w_next          = S_FETCH;
            end
            S_MEMWR: begin
                io_bus.mem_req  = 1'b1;
                io_bus.iord     = 1'b1;
                io_bus.memwrite = 1'b1;
                if (io_bus.mem_ready) begin
                    w_next = S_FETCH;
                end else begin
                    w_mem_wait = 1'b1;
                    if (w_wait_hit) w_next = S_FAULT;
                end
            end
            S_RTYPEEX: begin
                io_bus.alusrca = 1'b1;
                io_bus.alusrcb = SRCB_B;
                w_cls          = CLS_RTYPE;
                w_next         = w_legal ? S_RTYPEWB : S_FAULT;
            end
            S_RTYPEWB: begin
                io_bus.regwrite = 1'b1;
                io_bus.regdst   = REGDST_RD;
                w_next          = S_FETCH;
            end
            S_BREX: begin
                io_bus.alusrca = 1'b1;
                io_bus.pcsrc   = PCSRC_ALUOUT;
                w_cls          = CLS_SUB;
                io_bus.pcen    = (io_bus.op == OP_BNE) ? ~io_bus.zero : io_bus.zero;
                w_next         = S_FETCH;
            end
            S_IMMEX: begin
                io_bus.alusrca = 1'b1;
                io_bus.alusrcb = SRCB_IMM;
                w_cls          = CLS_IMM;
                w_next         = w_legal ? S_IMMWB : S_FAULT;
            end
            S_IMMWB: begin
                io_bus.regwrite = 1'b1;
                io_bus.regdst   = REGDST_RT;
                w_cls           = CLS_IMM;
                w_next          = S_FETCH;
            end
            S_JEX: begin
                io_bus.pcsrc = PCSRC_JUMP;
                io_bus.pcen  = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef MC_JAL_EN
            S_JALEX: begin
                io_bus.pcsrc    = PCSRC_JUMP;
                io_bus.pcen     = 1'b1;
                io_bus.regwrite = 1'b1;
                io_bus.regdst   = REGDST_RA;
                io_bus.memtoreg = M2R_PC;
                w_next          = S_FETCH;
            end
`endif
            S_FAULT: io_bus.fault = 1'b1;
            default: w_next = S_FAULT;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus queues per-cycle expected
// control words, and a negedge monitor pops and compares them.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_if #(.CNT_W(32)) bus ();

    mc_controller #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    typedef struct {
        logic [19:0] ctl;
        logic [19:0] msk;
        logic [31:0] ir;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [19:0] act;
    assign act = {bus.mem_req, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                  bus.alusrca, bus.iord, bus.extop, bus.regdst, bus.memtoreg,
                  bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.fault};

    function automatic logic [19:0] mk(input logic mr, pc, mw, irw, rw, sa, io, ex,
                                       input logic [1:0] rd, mt, sb, ps,
                                       input logic [2:0] ac, input logic ft);
        return {mr, pc, mw, irw, rw, sa, io, ex, rd, mt, sb, ps, ac, ft};
    endfunction

    logic [19:0] E_FW, E_FR, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR, E_RTWB, E_JEX, E_JAL, E_FLT;
    localparam logic [19:0] M_ALL   = 20'hFFFFF;
    localparam logic [19:0] M_NOALU = 20'hFFFF1;

    task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic z,
                        input logic rdy, input logic [19:0] ctl, input logic [31:0] ir,
                        input string name, input logic [19:0] msk = 20'hFFFFF);
        exp_t e;
        bus.op        = op;
        bus.funct     = funct;
        bus.zero      = z;
        bus.mem_ready = rdy;
        e.ctl  = ctl;
        e.msk  = msk;
        e.ir   = ir;
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if ((act & e.msk) === (e.ctl & e.msk)) n_pass++;
                else $display("FAIL %s ctl actual=%05h required=%05h", e.name, act & e.msk, e.ctl & e.msk);
                n_chk++;
                if (bus.instret === e.ir) n_pass++;
                else $display("FAIL %s instret actual=%0d required=%0d", e.name, bus.instret, e.ir);
            end
        end
    end

    initial begin
        E_FW   = mk(1,0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 3'd2, 0);
        E_FR   = mk(1,1,0,1,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 3'd2, 0);
        E_DEC  = mk(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd3,2'd0, 3'd2, 0);
        E_MADR = mk(0,0,0,0,0,1,0,0, 2'd0,2'd0,2'd2,2'd0, 3'd2, 0);
        E_MRD  = mk(1,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 3'd0, 0);
        E_MWB  = mk(0,0,0,0,1,0,0,0, 2'd0,2'd1,2'd0,2'd0, 3'd0, 0);
        E_MWR  = mk(1,0,1,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 3'd0, 0);
        E_RTWB = mk(0,0,0,0,1,0,0,0, 2'd1,2'd0,2'd0,2'd0, 3'd0, 0);
        E_JEX  = mk(0,1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd2, 3'd0, 0);
        E_JAL  = mk(0,1,0,0,1,0,0,0, 2'd2,2'd2,2'd0,2'd2, 3'd0, 0);
        E_FLT  = mk(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0, 1);

        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        do_reset();

        // lw with no wait states: 5 cycles, then instret 1
        step(OP_LW, 6'd0, 0, 1, E_FR,   0, "lw_fetch");
        step(OP_LW, 6'd0, 0, 1, E_DEC,  0, "lw_decode");
        step(OP_LW, 6'd0, 0, 1, E_MADR, 0, "lw_memadr");
        step(OP_LW, 6'd0, 0, 1, E_MRD,  0, "lw_memrd");
        step(OP_LW, 6'd0, 0, 1, E_MWB,  0, "lw_memwb");
        step(OP_SW, 6'd0, 0, 1, E_FR,   1, "sw_fetch");
        step(OP_SW, 6'd0, 0, 1, E_DEC,  1, "sw_decode");
        step(OP_SW, 6'd0, 0, 1, E_MADR, 1, "sw_memadr");
        step(OP_SW, 6'd0, 0, 1, E_MWR,  1, "sw_memwr");
        // fetch stalls 3 cycles; completes exactly when the count would hit MAX_WAIT
        step(OP_RTYPE, F_ADD, 0, 0, E_FW, 2, "stall_1");
        step(OP_RTYPE, F_ADD, 0, 0, E_FW, 2, "stall_2");
        step(OP_RTYPE, F_ADD, 0, 0, E_FW, 2, "stall_3");
        step(OP_RTYPE, F_ADD, 0, 1, E_FR, 2, "stall_done");
        step(OP_RTYPE, F_ADD, 0, 1, E_DEC, 2, "add_decode");
        step(OP_RTYPE, F_ADD, 0, 1, mk(0,0,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd2,0), 2, "add_ex");
        step(OP_RTYPE, F_ADD, 0, 1, E_RTWB, 2, "add_wb");
        step(OP_RTYPE, F_XOR, 0, 1, E_FR, 3, "xor_fetch");
        step(OP_RTYPE, F_XOR, 0, 1, E_DEC, 3, "xor_decode");
        step(OP_RTYPE, F_XOR, 0, 1, mk(0,0,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd3,0), 3, "xor_ex");
        step(OP_RTYPE, F_XOR, 0, 1, E_RTWB, 3, "xor_wb");
        // branches
        step(OP_BNE, 6'd0, 0, 1, E_FR, 4, "bne_fetch");
        step(OP_BNE, 6'd0, 0, 1, E_DEC, 4, "bne_decode");
        step(OP_BNE, 6'd0, 0, 1, mk(0,1,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd1,3'd6,0), 4, "bne_z0");
        step(OP_BEQ, 6'd0, 0, 1, E_FR, 5, "beq_fetch");
        step(OP_BEQ, 6'd0, 0, 1, E_DEC, 5, "beq_decode");
        step(OP_BEQ, 6'd0, 0, 1, mk(0,0,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd1,3'd6,0), 5, "beq_z0");
        step(OP_BEQ, 6'd0, 1, 1, E_FR, 6, "beq1_fetch");
        step(OP_BEQ, 6'd0, 1, 1, E_DEC, 6, "beq1_decode");
        step(OP_BEQ, 6'd0, 1, 1, mk(0,1,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd1,3'd6,0), 6, "beq_z1");
        // immediates
        step(OP_ORI, 6'd0, 0, 1, E_FR, 7, "ori_fetch");
        step(OP_ORI, 6'd0, 0, 1, E_DEC, 7, "ori_decode");
        step(OP_ORI, 6'd0, 0, 1, mk(0,0,0,0,0,1,0,1,2'd0,2'd0,2'd2,2'd0,3'd1,0), 7, "ori_ex");
        step(OP_ORI, 6'd0, 0, 1, mk(0,0,0,0,1,0,0,1,2'd0,2'd0,2'd0,2'd0,3'd1,0), 7, "ori_wb");
        step(OP_SLTI, 6'd0, 0, 1, E_FR, 8, "slti_fetch");
        step(OP_SLTI, 6'd0, 0, 1, E_DEC, 8, "slti_decode");
        step(OP_SLTI, 6'd0, 0, 1, mk(0,0,0,0,0,1,0,0,2'd0,2'd0,2'd2,2'd0,3'd7,0), 8, "slti_ex");
        step(OP_SLTI, 6'd0, 0, 1, mk(0,0,0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd7,0), 8, "slti_wb");
        step(OP_J, 6'd0, 0, 1, E_FR, 9, "j_fetch");
        step(OP_J, 6'd0, 0, 1, E_DEC, 9, "j_decode");
        step(OP_J, 6'd0, 0, 1, E_JEX, 9, "j_ex");
        // lw with two MEMRD wait states
        step(OP_LW, 6'd0, 0, 1, E_FR, 10, "lw2_fetch");
        step(OP_LW, 6'd0, 0, 1, E_DEC, 10, "lw2_decode");
        step(OP_LW, 6'd0, 0, 1, E_MADR, 10, "lw2_memadr");
        step(OP_LW, 6'd0, 0, 0, E_MRD, 10, "lw2_wait1");
        step(OP_LW, 6'd0, 0, 0, E_MRD, 10, "lw2_wait2");
        step(OP_LW, 6'd0, 0, 1, E_MRD, 10, "lw2_memrd");
        step(OP_LW, 6'd0, 0, 1, E_MWB, 10, "lw2_memwb");
        step(OP_JAL, 6'd0, 0, 1, E_FR, 11, "jal_fetch");
        step(OP_JAL, 6'd0, 0, 1, E_DEC, 11, "jal_decode");
`ifdef MC_JAL_EN
        step(OP_JAL, 6'd0, 0, 1, E_JAL, 11, "jal_ex");
        step(6'h3F, 6'd0, 0, 1, E_FR, 12, "after_jal");
`else
        step(OP_JAL, 6'd0, 0, 1, E_FLT, 11, "jal_fault");
        step(OP_JAL, 6'd0, 0, 1, E_FLT, 11, "jal_fault_hold");
`endif
        do_reset();
        // illegal opcode
        step(6'h3F, 6'd0, 0, 1, E_FR, 0, "badop_fetch");
        step(6'h3F, 6'd0, 0, 1, E_DEC, 0, "badop_decode");
        step(6'h3F, 6'd0, 0, 1, E_FLT, 0, "badop_fault");
        step(6'h3F, 6'd0, 1, 1, E_FLT, 0, "badop_hold");
        do_reset();
        // illegal funct
        step(OP_RTYPE, 6'b000111, 0, 1, E_FR, 0, "badfn_fetch");
        step(OP_RTYPE, 6'b000111, 0, 1, E_DEC, 0, "badfn_decode");
        step(OP_RTYPE, 6'b000111, 0, 1, mk(0,0,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0), 0, "badfn_ex", M_NOALU);
        step(OP_RTYPE, 6'b000111, 0, 1, E_FLT, 0, "badfn_fault");
        step(OP_RTYPE, 6'b000111, 0, 1, E_FLT, 0, "badfn_hold");
        do_reset();
        // reset in the middle of MEMWR
        step(OP_RTYPE, F_AND, 0, 1, E_FR, 0, "and_fetch");
        step(OP_RTYPE, F_AND, 0, 1, E_DEC, 0, "and_decode");
        step(OP_RTYPE, F_AND, 0, 1, mk(0,0,0,0,0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0), 0, "and_ex");
        step(OP_RTYPE, F_AND, 0, 1, E_RTWB, 0, "and_wb");
        step(OP_SW, 6'd0, 0, 1, E_FR, 1, "swr_fetch");
        step(OP_SW, 6'd0, 0, 1, E_DEC, 1, "swr_decode");
        step(OP_SW, 6'd0, 0, 1, E_MADR, 1, "swr_memadr");
        step(OP_SW, 6'd0, 0, 0, E_MWR, 1, "swr_memwr");
        do_reset();
        step(OP_SW, 6'd0, 0, 0, E_FW, 0, "post_reset");
        // watchdog: sw stalled past MAX_WAIT
        step(OP_SW, 6'd0, 0, 1, E_FR, 0, "wd_fetch");
        step(OP_SW, 6'd0, 0, 1, E_DEC, 0, "wd_decode");
        step(OP_SW, 6'd0, 0, 1, E_MADR, 0, "wd_memadr");
        step(OP_SW, 6'd0, 0, 0, E_MWR, 0, "wd_wait1");
        step(OP_SW, 6'd0, 0, 0, E_MWR, 0, "wd_wait2");
        step(OP_SW, 6'd0, 0, 0, E_MWR, 0, "wd_wait3");
        step(OP_SW, 6'd0, 0, 0, E_MWR, 0, "wd_wait4");
        step(OP_SW, 6'd0, 0, 0, E_FLT, 0, "wd_fault");
        step(OP_SW, 6'd0, 0, 1, E_FLT, 0, "wd_hold1");
        step(OP_SW, 6'd0, 0, 1, E_FLT, 0, "wd_hold2");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain queued=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
